idex_hazard_register: RTL and testbench
=======================================

Name: idex_hazard_register

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, bubble insertion and branch flush for the 5-stage RISC-V core.
- Captures decoded operands and control from ID and presents IDEX_Rs1, IDEX_Rs2, IDEX_rd and IDEX_RegWrite to the EX-stage forwarding logic.
- Drives the PC/IF-ID write enables.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- XLEN, 32, datapath width of register-read data, immediate and PC.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- ID_valid  in  1  ID stage holds a real instruction
- ID_Rs1, ID_Rs2, ID_rd  in  5 each  register fields from IF/ID
- ID_uses_rs1, ID_uses_rs2  in  1 each  instruction actually reads that source
- ID_read_data1, ID_read_data2  in  XLEN each  register-file read data
- ID_imm, ID_pc  in  XLEN each  immediate and PC
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Branch  in  1 each  decoded control
- ID_ALUOp  in  2  decoded ALU op class
- EX_flush  in  1  taken branch/jump resolved in EX this cycle
- clr_counters  in  1  synchronous clear of both counters
- IDEX_valid  out  1  registered valid
- IDEX_Rs1, IDEX_Rs2, IDEX_rd  out  5 each  registered register fields
- IDEX_read_data1, IDEX_read_data2, IDEX_imm, IDEX_pc  out  XLEN each  registered data
- IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc, IDEX_Branch  out  1 each  registered control
- IDEX_ALUOp  out  2  registered ALU op
- PC_Write, IFID_Write  out  1 each  combinational; 0 holds PC and IF/ID
- IFID_Flush  out  1  combinational; equals EX_flush
- stall_count, flush_count  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output goes to 0, including all data, control, valid, register fields and both counters. Combinational outputs follow from the reset state: PC_Write=1, IFID_Write=1.
- Hazard condition (combinational), load_use is true when all of the following hold:
  - IDEX_valid and IDEX_MemRead
  - IDEX_rd != 0
  - ID_valid
  - (ID_uses_rs1 and ID_Rs1 == IDEX_rd) or (ID_uses_rs2 and ID_Rs2 == IDEX_rd)
- Per-edge update, in priority order:
  - EX_flush=1: load a bubble. valid=0, all six 1-bit controls=0, ALUOp=0; register fields and data are don't-care (implementation zeroes them). PC_Write=1, IFID_Write=1. Flush overrides stall in the same cycle. flush_count increments.
  - else load_use=1: load a bubble. PC_Write=0 and IFID_Write=0 in the same cycle. stall_count increments.
  - else: capture all ID_* fields verbatim and set valid=ID_valid. Controls of an invalid instruction (ID_valid=0) are forced to 0.
- Latency: one cycle from ID inputs to IDEX outputs. A load-use stall is exactly one bubble, because the next cycle the load sits in EX/MEM and is no longer in ID/EX.
- Back-to-back loads: the second load's dependency is re-evaluated each cycle, with no stale state.
- Counters:
  - CNT_W-bit; saturate at all-ones and never wrap.
  - clr_counters has priority over increment and zeroes both counters on the edge.
- Reset mid-stall: on release, registers are empty and no stall is asserted.
- There are no further states. The block behaves as a 2-state machine {PASS, BUBBLE} derived purely from current inputs, with no multi-cycle FSM.

Decomposition:
- Shared package pipe_pkg: XLEN default, the control-bundle struct/typedef (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp), the BUBBLE_CTRL all-zero constant and the ALUOp encodings.
- One sub-module, sat_counter (width param, inc, clr, count), instantiated twice for stall_count and flush_count.

Test Plan:
- Reset: assert rst_n=0 mid-run with IDEX_MemRead=1 → all IDEX_* outputs and counters read 0 immediately; PC_Write=1, IFID_Write=1.
- Load-use stall:
  - Stimulus: lw x5 in ID/EX (rd=5, MemRead=1); ID holds add x6,x5,x7 (uses_rs1=1, Rs1=5).
  - Required: PC_Write=0 and IFID_Write=0 that cycle; next cycle IDEX_valid=0 with all controls 0; stall_count=1; the following cycle the add is captured with IDEX_Rs1=5.
- No false stall:
  - Stimulus: lw x0 followed by a user of x0; also lw x5 followed by addi x6,x1,5 with Rs2 field=5 but uses_rs2=0.
  - Required: no stall in either case; stall_count unchanged.
- Flush priority: EX_flush=1 in the same cycle load_use=1 → PC_Write=1, IFID_Flush=1, bubble loaded, flush_count=1, stall_count unchanged.
- Pass-through:
  - Stimulus: ID_read_data1=32'hDEADBEEF, ID_imm=32'hFFFFF800, ID_pc=32'h100, RegWrite=1, ALUOp=2'b10.
  - Required: exactly those values on IDEX_* one edge later.
- Counter saturation and clear:
  - Stimulus: with CNT_W=4, apply 20 consecutive flushes.
  - Required: flush_count holds at 15; clr_counters=1 together with a flush leaves 0 on the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: control bundle carried from ID to EX, ALU op classes and widths.
package pipe_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/idex_hazard_register.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion on stall or
// branch flush, and saturating debug counters for both events.
module idex_hazard_register
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_valid,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic [XLEN-1:0]  ID_read_data1,
    input  logic [XLEN-1:0]  ID_read_data2,
    input  logic [XLEN-1:0]  ID_imm,
    input  logic [XLEN-1:0]  ID_pc,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_MemWrite,
    input  logic             ID_MemtoReg,
    input  logic             ID_ALUSrc,
    input  logic             ID_Branch,
    input  logic [1:0]       ID_ALUOp,
    input  logic             EX_flush,
    input  logic             clr_counters,
    output logic             IDEX_valid,
    output logic [4:0]       IDEX_Rs1,
    output logic [4:0]       IDEX_Rs2,
    output logic [4:0]       IDEX_rd,
    output logic [XLEN-1:0]  IDEX_read_data1,
    output logic [XLEN-1:0]  IDEX_read_data2,
    output logic [XLEN-1:0]  IDEX_imm,
    output logic [XLEN-1:0]  IDEX_pc,
    output logic             IDEX_RegWrite,
    output logic             IDEX_MemRead,
    output logic             IDEX_MemWrite,
    output logic             IDEX_MemtoReg,
    output logic             IDEX_ALUSrc,
    output logic             IDEX_Branch,
    output logic [1:0]       IDEX_ALUOp,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic            valid_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0] rdata1_q, rdata2_q, imm_q, pc_q;
    ctrl_t           ctrl_q;
    ctrl_t           id_ctrl;
    logic            src_match;
    logic            load_use;
    logic            stall;
    logic            bubble;

    assign id_ctrl = '{
        reg_write:  ID_RegWrite,
        mem_read:   ID_MemRead,
        mem_write:  ID_MemWrite,
        mem_to_reg: ID_MemtoReg,
        alu_src:    ID_ALUSrc,
        branch:     ID_Branch,
        alu_op:     ID_ALUOp
    };

    // Only sources the instruction really reads count; x0 is never a true dependency.
    assign src_match = (ID_uses_rs1 && (ID_Rs1 == rd_q)) || (ID_uses_rs2 && (ID_Rs2 == rd_q));
    assign load_use  = valid_q && ctrl_q.mem_read && (rd_q != 5'd0) && ID_valid && src_match;
    assign stall     = load_use && !EX_flush;
    assign bubble    = EX_flush || load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            ctrl_q   <= BUBBLE_CTRL;
        end else if (bubble) begin
            valid_q  <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            ctrl_q   <= BUBBLE_CTRL;
        end else begin
            valid_q  <= ID_valid;
            rs1_q    <= ID_Rs1;
            rs2_q    <= ID_Rs2;
            rd_q     <= ID_rd;
            rdata1_q <= ID_read_data1;
            rdata2_q <= ID_read_data2;
            imm_q    <= ID_imm;
            pc_q     <= ID_pc;
            ctrl_q   <= ID_valid ? id_ctrl : BUBBLE_CTRL;
        end
    end

    assign PC_Write   = !stall;
    assign IFID_Write = !stall;
    assign IFID_Flush = EX_flush;

    assign IDEX_valid      = valid_q;
    assign IDEX_Rs1        = rs1_q;
    assign IDEX_Rs2        = rs2_q;
    assign IDEX_rd         = rd_q;
    assign IDEX_read_data1 = rdata1_q;
    assign IDEX_read_data2 = rdata2_q;
    assign IDEX_imm        = imm_q;
    assign IDEX_pc         = pc_q;
    assign IDEX_RegWrite   = ctrl_q.reg_write;
    assign IDEX_MemRead    = ctrl_q.mem_read;
    assign IDEX_MemWrite   = ctrl_q.mem_write;
    assign IDEX_MemtoReg   = ctrl_q.mem_to_reg;
    assign IDEX_ALUSrc     = ctrl_q.alu_src;
    assign IDEX_Branch     = ctrl_q.branch;
    assign IDEX_ALUOp      = ctrl_q.alu_op;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .clr   (clr_counters),
        .count (stall_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (EX_flush),
        .clr   (clr_counters),
        .count (flush_count)
    );

endmodule

// File: tb/tb_idex_hazard_register.sv
// Randomised + directed bench for idex_hazard_register: a driver pushes expected behaviour
// into a queue each cycle, a monitor pops and compares just before the next rising edge.
module tb_idex_hazard_register;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk, rst_n;
    logic             ID_valid, ID_uses_rs1, ID_uses_rs2;
    logic [4:0]       ID_Rs1, ID_Rs2, ID_rd;
    logic [XLEN-1:0]  ID_read_data1, ID_read_data2, ID_imm, ID_pc;
    logic             ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Branch;
    logic [1:0]       ID_ALUOp;
    logic             EX_flush, clr_counters;
    logic             IDEX_valid;
    logic [4:0]       IDEX_Rs1, IDEX_Rs2, IDEX_rd;
    logic [XLEN-1:0]  IDEX_read_data1, IDEX_read_data2, IDEX_imm, IDEX_pc;
    logic             IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg;
    logic             IDEX_ALUSrc, IDEX_Branch;
    logic [1:0]       IDEX_ALUOp;
    logic             PC_Write, IFID_Write, IFID_Flush;
    logic [CNT_W-1:0] stall_count, flush_count;

    idex_hazard_register #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ID_valid        (ID_valid),
        .ID_Rs1          (ID_Rs1),
        .ID_Rs2          (ID_Rs2),
        .ID_rd           (ID_rd),
        .ID_uses_rs1     (ID_uses_rs1),
        .ID_uses_rs2     (ID_uses_rs2),
        .ID_read_data1   (ID_read_data1),
        .ID_read_data2   (ID_read_data2),
        .ID_imm          (ID_imm),
        .ID_pc           (ID_pc),
        .ID_RegWrite     (ID_RegWrite),
        .ID_MemRead      (ID_MemRead),
        .ID_MemWrite     (ID_MemWrite),
        .ID_MemtoReg     (ID_MemtoReg),
        .ID_ALUSrc       (ID_ALUSrc),
        .ID_Branch       (ID_Branch),
        .ID_ALUOp        (ID_ALUOp),
        .EX_flush        (EX_flush),
        .clr_counters    (clr_counters),
        .IDEX_valid      (IDEX_valid),
        .IDEX_Rs1        (IDEX_Rs1),
        .IDEX_Rs2        (IDEX_Rs2),
        .IDEX_rd         (IDEX_rd),
        .IDEX_read_data1 (IDEX_read_data1),
        .IDEX_read_data2 (IDEX_read_data2),
        .IDEX_imm        (IDEX_imm),
        .IDEX_pc         (IDEX_pc),
        .IDEX_RegWrite   (IDEX_RegWrite),
        .IDEX_MemRead    (IDEX_MemRead),
        .IDEX_MemWrite   (IDEX_MemWrite),
        .IDEX_MemtoReg   (IDEX_MemtoReg),
        .IDEX_ALUSrc     (IDEX_ALUSrc),
        .IDEX_Branch     (IDEX_Branch),
        .IDEX_ALUOp      (IDEX_ALUOp),
        .PC_Write        (PC_Write),
        .IFID_Write      (IFID_Write),
        .IFID_Flush      (IFID_Flush),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    // ctl bit order: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch}
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [31:0] d1, d2, imm, pc;
        logic [5:0]  ctl;
        logic [1:0]  aluop;
        logic        flush, clr;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm, pc;
        logic [5:0]  ctl;
        logic [1:0]  aluop;
        logic [3:0]  stalls, flushes;
    } mstate_t;

    typedef struct packed {
        logic [2:0] haz;   // {PC_Write, IFID_Write, IFID_Flush}
        mstate_t    st;
    } exp_t;

    exp_t    exp_q[$];
    mstate_t ms;
    int      errors = 0;
    int      checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // A load sitting in ID/EX blocks any instruction in ID that reads the register it writes.
    function automatic logic model_hazard(input mstate_t m, input stim_t s);
        logic is_load;
        logic reads_it;
        is_load  = m.valid && m.ctl[4] && (m.rd != 0);
        reads_it = (s.u1 && s.rs1 == m.rd) || (s.u2 && s.rs2 == m.rd);
        return is_load && s.valid && reads_it;
    endfunction

    function automatic logic [3:0] sat_add(input logic [3:0] v, input logic inc);
        int n;
        n = int'(v) + (inc ? 1 : 0);
        if (n > 15) n = 15;
        return 4'(n);
    endfunction

    function automatic mstate_t model_next(input mstate_t m, input stim_t s);
        mstate_t n;
        logic    hz;
        hz = model_hazard(m, s);
        n  = '0;
        if (!(s.flush || hz)) begin
            n.valid = s.valid;
            n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd;
            n.d1 = s.d1; n.d2 = s.d2; n.imm = s.imm; n.pc = s.pc;
            n.ctl   = s.valid ? s.ctl : 6'b0;
            n.aluop = s.valid ? s.aluop : 2'b0;
        end
        if (s.clr) begin
            n.stalls  = 0;
            n.flushes = 0;
        end else begin
            n.stalls  = sat_add(m.stalls, hz && !s.flush);
            n.flushes = sat_add(m.flushes, s.flush);
        end
        return n;
    endfunction

    task automatic apply(input stim_t s);
        ID_valid = s.valid; ID_Rs1 = s.rs1; ID_Rs2 = s.rs2; ID_rd = s.rd;
        ID_uses_rs1 = s.u1; ID_uses_rs2 = s.u2;
        ID_read_data1 = s.d1; ID_read_data2 = s.d2; ID_imm = s.imm; ID_pc = s.pc;
        {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Branch} = s.ctl;
        ID_ALUOp = s.aluop;
        EX_flush = s.flush;
        clr_counters = s.clr;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        logic stall;
        @(negedge clk); #1;
        rst_n = 1'b1;
        apply(s);
        stall = model_hazard(ms, s) && !s.flush;
        e.haz = {!stall, !stall, s.flush};
        e.st  = ms;
        exp_q.push_back(e);
        ms = model_next(ms, s);
    endtask

    // Reset asserted mid-cycle; state must clear before the next edge.
    task automatic reset_cycle(input stim_t s);
        exp_t e;
        @(negedge clk); #1;
        apply(s);
        rst_n = 1'b0;
        ms = '0;
        e.haz = {1'b1, 1'b1, s.flush};
        e.st  = ms;
        exp_q.push_back(e);
    endtask

    function automatic stim_t load(input logic [4:0] rd);
        stim_t s;
        s = nop();
        s.valid = 1'b1; s.rs1 = 5'd2; s.u1 = 1'b1; s.rd = rd;
        s.imm = 32'h10; s.pc = 32'h40;
        s.ctl = 6'b110110;
        return s;
    endfunction

    function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2);
        stim_t s;
        s = nop();
        s.valid = 1'b1; s.rd = rd; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
        s.d1 = 32'h1111; s.d2 = 32'h2222; s.pc = 32'h44;
        s.ctl = 6'b100000; s.aluop = 2'b10;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.valid = ($urandom_range(0, 7) != 0);
        s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
        s.rd  = 5'($urandom_range(0, 3));
        s.u1 = 1'($urandom); s.u2 = 1'($urandom);
        s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom; s.pc = $urandom;
        s.ctl = 6'($urandom);
        s.aluop = 2'($urandom);
        s.flush = ($urandom_range(0, 7) == 0);
        s.clr = ($urandom_range(0, 39) == 0);
        return s;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hazard_outs", {PC_Write, IFID_Write, IFID_Flush}, e.haz);
                check("valid", IDEX_valid, e.st.valid);
                check("reg_fields", {IDEX_Rs1, IDEX_Rs2, IDEX_rd}, {e.st.rs1, e.st.rs2, e.st.rd});
                check("data", {IDEX_read_data1, IDEX_read_data2, IDEX_imm, IDEX_pc},
                      {e.st.d1, e.st.d2, e.st.imm, e.st.pc});
                check("ctrl", {IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg,
                               IDEX_ALUSrc, IDEX_Branch, IDEX_ALUOp}, {e.st.ctl, e.st.aluop});
                check("stall_count", stall_count, e.st.stalls);
                check("flush_count", flush_count, e.st.flushes);
            end
        end
    end

    initial begin : driver
        stim_t s;
        rst_n = 1'b0;
        ms = '0;
        apply(nop());
        reset_cycle(nop());

        // Load-use: stall once, then the held add is captured.
        step(load(5'd5));
        step(alu(5'd6, 5'd5, 1'b1, 5'd7, 1'b1));
        step(alu(5'd6, 5'd5, 1'b1, 5'd7, 1'b1));
        step(nop());

        // No false stall: load to x0, and a matching but unused rs2 field.
        step(load(5'd0));
        step(alu(5'd6, 5'd0, 1'b1, 5'd0, 1'b1));
        step(load(5'd5));
        step(alu(5'd6, 5'd1, 1'b1, 5'd5, 1'b0));

        // Flush in the same cycle as a load-use hazard.
        step(load(5'd5));
        s = alu(5'd6, 5'd5, 1'b1, 5'd7, 1'b1);
        s.flush = 1'b1;
        step(s);
        step(nop());

        // Back-to-back loads with a chained dependency.
        step(load(5'd3));
        s = load(5'd4);
        s.rs1 = 5'd3;
        step(s);
        step(s);
        step(alu(5'd6, 5'd4, 1'b1, 5'd0, 1'b0));
        step(alu(5'd6, 5'd4, 1'b1, 5'd0, 1'b0));

        // Pass-through of exact values.
        s = nop();
        s.valid = 1'b1; s.d1 = 32'hDEADBEEF; s.imm = 32'hFFFFF800; s.pc = 32'h100;
        s.ctl = 6'b100000; s.aluop = 2'b10;
        step(s);
        s.valid = 1'b0;
        step(s);
        step(nop());

        // Flush counter saturates, then clear together with a flush.
        for (int i = 0; i < 20; i++) begin
            s = rand_stim();
            s.flush = 1'b1; s.clr = 1'b0;
            step(s);
        end
        s = nop();
        s.flush = 1'b1; s.clr = 1'b1;
        step(s);
        step(nop());

        // Reset while a stall is pending.
        step(load(5'd5));
        s = load(5'd5);
        s.ctl[4] = 1'b1;
        reset_cycle(alu(5'd6, 5'd5, 1'b1, 5'd7, 1'b1));
        step(alu(5'd6, 5'd5, 1'b1, 5'd7, 1'b1));
        step(nop());

        for (int i = 0; i < 400; i++) begin
            step(rand_stim());
        end
        step(nop());

        repeat (3) @(negedge clk);
        #4;
        check("queue_drained", 256'(exp_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
